// File: rtl/ir_nec_frame_decoder_pkg.sv
// Shared NEC frame-decoder definitions: cycle constants at 50 MHz, FSM
// encoding, byte lanes of the 32-bit frame and the inverse-byte check.
package ir_nec_frame_decoder_pkg;

  localparam int unsigned MARK_MAX_DEF   = 32'd50000;
  localparam int unsigned BIT_THRESH_DEF = 32'd56250;
  localparam int unsigned SPACE_TO_DEF   = 32'd125000;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FIRST = 3'd1,
    ST_MARK       = 3'd2,
    ST_SPACE      = 3'd3,
    ST_CHECK      = 3'd4
  } nec_state_e;

  localparam int ADDR_LSB     = 32'd0;
  localparam int ADDR_INV_LSB = 32'd8;
  localparam int CMD_LSB      = 32'd16;
  localparam int CMD_INV_LSB  = 32'd24;

  function automatic logic nec_frame_ok(input logic [31:0] frame);
    return (frame[ADDR_INV_LSB +: 8] == ~frame[ADDR_LSB +: 8]) &&
           (frame[CMD_INV_LSB +: 8]  == ~frame[CMD_LSB +: 8]);
  endfunction

endpackage

// File: rtl/ir_rxd_edge_sync.sv
// Brings the asynchronous IR receiver line into the clock domain and flags
// its rising and falling edges; all flops idle high like the line.
module ir_rxd_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // two-flop synchronizer followed by a delay flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
      s3_r <= 1'b1;
    end else begin
      s1_r <= rxd;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign fall = s3_r & ~s2_r;
  assign rise = ~s3_r & s2_r;

endmodule

// File: rtl/ir_nec_frame_decoder.sv
// NEC data-field decoder: after a leader, times mark/space of 32 bits,
// assembles them LSB-first and validates the inverted address/command bytes.
module ir_nec_frame_decoder
  import ir_nec_frame_decoder_pkg::*;
#(
  parameter int unsigned MARK_MAX   = MARK_MAX_DEF,
  parameter int unsigned BIT_THRESH = BIT_THRESH_DEF,
  parameter int unsigned SPACE_TO   = SPACE_TO_DEF
) (
  input  logic        CLOCK_50,
  input  logic        rst,
  input  logic        IRDA_RXD,
  input  logic        ldr_I,
  output logic [7:0]  addr_O,
  output logic [7:0]  cmd_O,
  output logic [31:0] data_O,
  output logic        data_valid_O,
  output logic        frame_err_O,
  output logic        busy_O
);

  logic        rise_s;
  logic        fall_s;
  logic        ldr_r;
  logic        ldr_rise_s;
  logic        bit_s;
  logic [31:0] sr_next_s;
  nec_state_e  state_r;
  logic [16:0] cnt_r;
  logic [4:0]  bit_cnt_r;
  logic [31:0] sr_r;
  logic [7:0]  addr_r;
  logic [7:0]  cmd_r;
  logic [31:0] data_r;
  logic        valid_r;
  logic        err_r;
  logic        busy_r;

  ir_rxd_edge_sync u_edge_sync (
    .clk  (CLOCK_50),
    .rst  (rst),
    .rxd  (IRDA_RXD),
    .rise (rise_s),
    .fall (fall_s)
  );

  assign ldr_rise_s = ldr_I & ~ldr_r;
  assign bit_s      = (cnt_r >= 17'(BIT_THRESH));
  assign sr_next_s  = {bit_s, sr_r[31:1]};

  // frame FSM with its counters, shift register and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ldr_r     <= 1'b0;
      cnt_r     <= 17'd0;
      bit_cnt_r <= 5'd0;
      sr_r      <= 32'd0;
      addr_r    <= 8'd0;
      cmd_r     <= 8'd0;
      data_r    <= 32'd0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      ldr_r   <= ldr_I;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ldr_rise_s) begin
            cnt_r     <= 17'd0;
            bit_cnt_r <= 5'd0;
            sr_r      <= 32'd0;
            busy_r    <= 1'b1;
            state_r   <= ST_WAIT_FIRST;
          end
        end
        ST_WAIT_FIRST: begin
          if (fall_s) begin
            cnt_r   <= 17'd0;
            state_r <= ST_MARK;
          end else if (cnt_r == 17'(SPACE_TO)) begin
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 17'd1;
          end
        end
        ST_MARK: begin
          if (rise_s) begin
            cnt_r   <= 17'd0;
            state_r <= ST_SPACE;
          end else if (cnt_r == 17'(MARK_MAX)) begin
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 17'd1;
          end
        end
        ST_SPACE: begin
          if (cnt_r == 17'(SPACE_TO)) begin
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else if (fall_s) begin
            sr_r      <= sr_next_s;
            bit_cnt_r <= bit_cnt_r + 5'd1;
            // the 32nd falling edge is the stop burst, not another data mark
            if (bit_cnt_r == 5'd31) begin
              state_r <= ST_CHECK;
            end else begin
              cnt_r   <= 17'd0;
              state_r <= ST_MARK;
            end
          end else begin
            cnt_r <= cnt_r + 17'd1;
          end
        end
        ST_CHECK: begin
          if (nec_frame_ok(sr_r)) begin
            data_r  <= sr_r;
            addr_r  <= sr_r[ADDR_LSB +: 8];
            cmd_r   <= sr_r[CMD_LSB +: 8];
            valid_r <= 1'b1;
          end else begin
            err_r <= 1'b1;
          end
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign addr_O       = addr_r;
  assign cmd_O        = cmd_r;
  assign data_O       = data_r;
  assign data_valid_O = valid_r;
  assign frame_err_O  = err_r;
  assign busy_O       = busy_r;

endmodule

// File: tb/tb_ir_nec_frame_decoder.sv
// Directed bench for ir_nec_frame_decoder with scaled-down cycle constants so
// whole frames fit in a short run; vectors table plus hand-written corner cases.
module tb_ir_nec_frame_decoder;

  localparam int MARK_MAX   = 40;
  localparam int BIT_THRESH = 45;
  localparam int SPACE_TO   = 100;
  localparam int MARK_CYC   = 15;
  localparam int SP_ZERO    = 15;
  localparam int SP_ONE     = 60;

  typedef struct {
    logic [31:0] tx;
    int          ovr_bit;
    int          ovr_sp;
    logic        exp_ok;
    logic [31:0] exp_data;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_cmd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        ldr = 1'b0;
  logic [7:0]  addr_O;
  logic [7:0]  cmd_O;
  logic [31:0] data_O;
  logic        data_valid_O;
  logic        frame_err_O;
  logic        busy_O;

  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int valid_cyc = -1;
  int err_cyc = -1;
  int n_vec = 0;
  int n_bad = 0;
  vec_t tab [7];

  ir_nec_frame_decoder #(
    .MARK_MAX   (MARK_MAX),
    .BIT_THRESH (BIT_THRESH),
    .SPACE_TO   (SPACE_TO)
  ) dut (
    .CLOCK_50     (clk),
    .rst          (rst),
    .IRDA_RXD     (rxd),
    .ldr_I        (ldr),
    .addr_O       (addr_O),
    .cmd_O        (cmd_O),
    .data_O       (data_O),
    .data_valid_O (data_valid_O),
    .frame_err_O  (frame_err_O),
    .busy_O       (busy_O)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor: counts every high cycle so stretched pulses show up
  always @(negedge clk) begin
    if (data_valid_O) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (frame_err_O) begin
      n_err   = n_err + 1;
      err_cyc = cyc;
    end
    if (data_valid_O && frame_err_O) begin
      n_vec = n_vec + 1;
      n_bad = n_bad + 1;
      $display("FAIL strobe_overlap: valid and err both high at cycle %0d", cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sp_for(input vec_t v, input int i);
    if (i == v.ovr_bit) return v.ovr_sp;
    return v.tx[i] ? SP_ONE : SP_ZERO;
  endfunction

  task automatic start_frame();
    ldr = 1'b1;
    @(negedge clk);
    check("busy_up", {31'd0, busy_O}, 32'd1);
    ldr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // sp is the counter value the decoder sees when the space ends
  task automatic send_bit(input int sp, input bit glitch);
    rxd = 1'b0;
    if (glitch) begin
      ldr = 1'b1;
      @(negedge clk);
      ldr = 1'b0;
      repeat (MARK_CYC - 1) @(negedge clk);
    end else begin
      repeat (MARK_CYC) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (sp + 1) @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v, input int glitch_bit);
    int k;
    int v0;
    int e0;
    v0 = n_valid;
    e0 = n_err;
    start_frame();
    for (int i = 0; i < 32; i++) send_bit(sp_for(v, i), (i == glitch_bit));
    rxd = 1'b0;
    k = cyc + 1;
    repeat (MARK_CYC) @(negedge clk);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    check("valid_count", n_valid - v0, {31'd0, v.exp_ok});
    check("err_count", n_err - e0, {31'd0, ~v.exp_ok});
    if (v.exp_ok) check("valid_latency", valid_cyc, k + 3);
    else          check("err_latency", err_cyc, k + 3);
    check("data_O", data_O, v.exp_data);
    check("addr_O", {24'd0, addr_O}, {24'd0, v.exp_addr});
    check("cmd_O", {24'd0, cmd_O}, {24'd0, v.exp_cmd});
    check("busy_down", {31'd0, busy_O}, 32'd0);
  endtask

  initial begin
    int j;
    int v0;
    int e0;
    tab[0] = '{32'hBA45FF00, -1, 0,              1'b1, 32'hBA45FF00, 8'h00, 8'h45};
    tab[1] = '{32'hBB45FF00, -1, 0,              1'b0, 32'hBA45FF00, 8'h00, 8'h45};
    tab[2] = '{32'h3CC3A55A, -1, 0,              1'b1, 32'h3CC3A55A, 8'h5A, 8'hC3};
    tab[3] = '{32'hBA45FF00, 0,  BIT_THRESH - 1, 1'b1, 32'hBA45FF00, 8'h00, 8'h45};
    tab[4] = '{32'hBA45FE01, 0,  BIT_THRESH,     1'b1, 32'hBA45FE01, 8'h01, 8'h45};
    tab[5] = '{32'h3CC3A55A, 8,  BIT_THRESH - 1, 1'b0, 32'hBA45FE01, 8'h01, 8'h45};
    tab[6] = '{32'h3CC3A55A, 31, BIT_THRESH,     1'b0, 32'hBA45FE01, 8'h01, 8'h45};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", data_O, 32'd0);
    check("rst_addr_cmd", {16'd0, addr_O, cmd_O}, 32'd0);
    check("rst_flags", {29'd0, data_valid_O, frame_err_O, busy_O}, 32'd0);

    for (int i = 0; i < 7; i++) apply_vec(tab[i], -1);

    // space stuck high after bit 10
    v0 = n_valid;
    e0 = n_err;
    start_frame();
    for (int i = 0; i < 10; i++) send_bit(sp_for(tab[2], i), 1'b0);
    rxd = 1'b0;
    repeat (MARK_CYC) @(negedge clk);
    rxd = 1'b1;
    j = cyc + 1;
    repeat (150) @(negedge clk);
    check("space_to_err", n_err - e0, 32'd1);
    check("space_to_valid", n_valid - v0, 32'd0);
    check("space_to_time", err_cyc, j + SPACE_TO + 3);
    check("space_to_busy", {31'd0, busy_O}, 32'd0);
    check("space_to_data", data_O, 32'hBA45FE01);
    apply_vec(tab[0], -1);

    // mark stuck low at bit 3
    e0 = n_err;
    start_frame();
    for (int i = 0; i < 3; i++) send_bit(sp_for(tab[2], i), 1'b0);
    rxd = 1'b0;
    j = cyc + 1;
    repeat (60) @(negedge clk);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("mark_err", n_err - e0, 32'd1);
    check("mark_time", err_cyc, j + MARK_MAX + 3);
    check("mark_busy", {31'd0, busy_O}, 32'd0);

    // extra leader pulse during bit 5 must be ignored
    apply_vec(tab[2], 5);

    // reset in the middle of a frame at bit 20
    v0 = n_valid;
    e0 = n_err;
    start_frame();
    for (int i = 0; i < 20; i++) send_bit(sp_for(tab[0], i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_data", data_O, 32'd0);
    check("mid_rst_addr_cmd", {16'd0, addr_O, cmd_O}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_O}, 32'd0);
    repeat (150) @(negedge clk);
    check("mid_rst_no_strobe", (n_valid - v0) + (n_err - e0), 32'd0);
    check("mid_rst_idle", {31'd0, busy_O}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
